// File: rtl/rf_wb_arbiter_pkg.sv
// Shared CPU types for register-file writeback: index/data widths and the
// buffered long-latency result entry.
package rf_wb_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 1 << REG_W;

  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  a3;
    logic [DATA_W-1:0] wd;
  } wb_entry_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
    reg_onehot = '0;
    reg_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular result buffer; every entry carries a live bit that an address-match
// kill can clear, so stale results are dropped at the head instead of written.
module wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  input  logic             kill_en,
  input  logic [REG_W-1:0] kill_a3,
  output wb_entry_t        head,
  output logic             empty,
  output logic             full,
  output logic [NREGS-1:0] busy_mask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  assign head  = entries[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && entries[i].live && (entries[i].a3 == kill_a3))
          entries[i].live <= 1'b0;
      end
      // Popped slots drop their live bit so busy_mask never sees stale entries.
      if (pop) begin
        entries[rd_ptr].live <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].live) busy_mask = busy_mask | reg_onehot(entries[i].a3);
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: pipeline writeback first, then buffered
// multiply/divide results, then a direct MDU bypass when the buffer is empty.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wr,
  input  logic [REG_W-1:0]  pipe_a3,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_W-1:0]  mdu_a3,
  input  logic [DATA_W-1:0] mdu_wd,
  output logic              RFWr,
  output logic [REG_W-1:0]  A3,
  output logic [DATA_W-1:0] WD,
  output logic [NREGS-1:0]  busy_mask
);

  wb_entry_t head;
  wb_entry_t push_entry;
  logic      empty;
  logic      full;
  logic      push;
  logic      pop;
  logic      kill_en;
  logic      eff_pipe;
  logic      mdu_xfer;
  logic      bypass;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (kill_en),
    .kill_a3    (pipe_a3),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .busy_mask  (busy_mask)
  );

  assign mdu_ready  = !full;
  assign push_entry = '{live: 1'b1, a3: mdu_a3, wd: mdu_wd};

  // Inputs are gated by rst_n so nothing reaches the register file during reset.
  always_comb begin
    eff_pipe = rst_n && pipe_wr && (pipe_a3 != '0);
    mdu_xfer = rst_n && mdu_valid && !full;
    RFWr     = 1'b0;
    A3       = '0;
    WD       = '0;
    pop      = 1'b0;
    bypass   = 1'b0;
    kill_en  = eff_pipe;
    if (eff_pipe) begin
      RFWr = 1'b1;
      A3   = pipe_a3;
      WD   = pipe_wd;
    end else if (!empty) begin
      pop = 1'b1;
      if (head.live) begin
        RFWr = 1'b1;
        A3   = head.a3;
        WD   = head.wd;
      end
    end else if (mdu_xfer && (mdu_a3 != '0)) begin
      bypass = 1'b1;
      RFWr   = 1'b1;
      A3     = mdu_a3;
      WD     = mdu_wd;
    end
    // r0 results and results already overwritten by the pipeline are dropped.
    push = mdu_xfer && (mdu_a3 != '0) && !bypass && !(eff_pipe && (mdu_a3 == pipe_a3));
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: expected register-file writes are queued
// with the stimulus and matched against every RFWr seen by the monitor.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  typedef struct {
    logic [REG_W-1:0]  a3;
    logic [DATA_W-1:0] wd;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pipe_wr;
  logic [REG_W-1:0]  pipe_a3;
  logic [DATA_W-1:0] pipe_wd;
  logic              mdu_valid;
  logic              mdu_ready;
  logic [REG_W-1:0]  mdu_a3;
  logic [DATA_W-1:0] mdu_wd;
  logic              RFWr;
  logic [REG_W-1:0]  A3;
  logic [DATA_W-1:0] WD;
  logic [NREGS-1:0]  busy_mask;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   acc;

  rf_wb_arbiter #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pipe_wr   (pipe_wr),
    .pipe_a3   (pipe_a3),
    .pipe_wd   (pipe_wd),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_a3    (mdu_a3),
    .mdu_wd    (mdu_wd),
    .RFWr      (RFWr),
    .A3        (A3),
    .WD        (WD),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [REG_W-1:0] a3, input logic [DATA_W-1:0] wd);
    exp_t e;
    e.a3 = a3;
    e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    pipe_wr   = 1'b0;
    pipe_a3   = '0;
    pipe_wd   = '0;
    mdu_valid = 1'b0;
    mdu_a3    = '0;
    mdu_wd    = '0;
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (RFWr) begin
      check("a3_nonzero", {31'b0, A3 == '0}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_wr", {27'b0, A3}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_a3", {27'b0, A3}, {27'b0, e.a3});
        check("wr_wd", WD, e.wd);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n     = 1'b0;
    pipe_wr   = 1'b1;
    pipe_a3   = 5'd3;
    pipe_wd   = 32'h1234;
    mdu_valid = 1'b1;
    mdu_a3    = 5'd6;
    #3;
    check("rst_rfwr", {31'b0, RFWr}, 32'd0);
    check("rst_a3", {27'b0, A3}, 32'd0);
    check("rst_wd", WD, 32'd0);
    check("rst_ready", {31'b0, mdu_ready}, 32'd1);
    check("rst_busy", busy_mask, 32'd0);
    tick();
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    // Idle buffer: MDU result bypasses straight to the register file.
    expect_wr(5'd5, 32'h11);
    mdu_valid = 1'b1;
    mdu_a3    = 5'd5;
    mdu_wd    = 32'h11;
    #3;
    check("bypass_ready", {31'b0, mdu_ready}, 32'd1);
    tick();
    idle();
    check("bypass_busy", busy_mask, 32'd0);
    check("bypass_q", exp_q.size(), 32'd0);

    // Pipeline hogs the port; MDU fills the buffer then stalls.
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      expect_wr(5'd3, 32'h300 + i);
      pipe_wr   = 1'b1;
      pipe_a3   = 5'd3;
      pipe_wd   = 32'h300 + i;
      mdu_valid = 1'b1;
      mdu_a3    = 5'(7 + acc);
      mdu_wd    = 32'h700 + acc;
      #3;
      check($sformatf("fill_ready%0d", i), {31'b0, mdu_ready}, (i < 4) ? 32'd1 : 32'd0);
      if (mdu_ready) acc++;
      tick();
    end
    check("fill_acc", acc, 32'd4);
    check("fill_busy", busy_mask, 32'h0000_0780);
    for (int k = 0; k < 4; k++) expect_wr(5'(7 + k), 32'h700 + k);
    idle();
    #3;
    check("full_ready_novalid", {31'b0, mdu_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("drain_q%0d", k), exp_q.size(), 32'(3 - k));
    end
    check("drain_busy", busy_mask, 32'd0);
    tick();

    // Buffered r9 is overwritten by the pipeline before it drains.
    expect_wr(5'd1, 32'h1);
    pipe_wr   = 1'b1;
    pipe_a3   = 5'd1;
    pipe_wd   = 32'h1;
    mdu_valid = 1'b1;
    mdu_a3    = 5'd9;
    mdu_wd    = 32'hAA;
    tick();
    check("kill_busy_set", busy_mask, 32'h0000_0200);
    idle();
    expect_wr(5'd9, 32'hBB);
    pipe_wr = 1'b1;
    pipe_a3 = 5'd9;
    pipe_wd = 32'hBB;
    tick();
    check("kill_busy_clr", busy_mask, 32'd0);
    idle();
    tick();
    tick();
    check("kill_q", exp_q.size(), 32'd0);

    // Same-cycle pipeline and MDU writes to r4: MDU result is discarded.
    expect_wr(5'd4, 32'h1);
    pipe_wr   = 1'b1;
    pipe_a3   = 5'd4;
    pipe_wd   = 32'h1;
    mdu_valid = 1'b1;
    mdu_a3    = 5'd4;
    mdu_wd    = 32'h2;
    #3;
    check("same_ready", {31'b0, mdu_ready}, 32'd1);
    tick();
    idle();
    check("same_busy", busy_mask, 32'd0);
    tick();
    tick();
    check("same_q", exp_q.size(), 32'd0);

    // MDU result for r0 is accepted and dropped.
    mdu_valid = 1'b1;
    mdu_a3    = 5'd0;
    mdu_wd    = 32'hFF;
    #3;
    check("r0_ready", {31'b0, mdu_ready}, 32'd1);
    check("r0_rfwr", {31'b0, RFWr}, 32'd0);
    tick();
    idle();
    check("r0_busy", busy_mask, 32'd0);
    tick();

    // Reset with three entries buffered discards them.
    for (int i = 0; i < 3; i++) begin
      expect_wr(5'd2, 32'h200 + i);
      pipe_wr   = 1'b1;
      pipe_a3   = 5'd2;
      pipe_wd   = 32'h200 + i;
      mdu_valid = 1'b1;
      mdu_a3    = 5'(20 + i);
      mdu_wd    = 32'hD00 + i;
      tick();
    end
    idle();
    check("rst3_busy_pre", busy_mask, 32'h0070_0000);
    rst_n = 1'b0;
    #1;
    check("rst3_rfwr", {31'b0, RFWr}, 32'd0);
    check("rst3_busy", busy_mask, 32'd0);
    check("rst3_ready", {31'b0, mdu_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("rst3_q", exp_q.size(), 32'd0);
    check("rst3_busy_post", busy_mask, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
